// File: rtl/sprite_pixel_scheduler_if.sv
// Bundle between the per-frame sprite scheduler and its surroundings.
// The frame control, the drawer pixel streams and the VGA pixel port travel together.
// The slave modport is the scheduler's view of the bundle.
// The master modport is the view of whatever drives frames and drawers.
interface sprite_pixel_scheduler_if #(
    parameter int N_SPRITES = 7
);
    logic                     frame_tick;
    logic [N_SPRITES-1:0]     enable_mask;
    logic [8*N_SPRITES-1:0]   sprite_x;
    logic [7*N_SPRITES-1:0]   sprite_y;
    logic [3*N_SPRITES-1:0]   sprite_colour;
    logic [N_SPRITES-1:0]     sprite_done;

    logic [N_SPRITES-1:0]     start;
    logic                     erase;
    logic [7:0]               vga_x;
    logic [6:0]               vga_y;
    logic [2:0]               vga_colour;
    logic                     vga_plot;
    logic                     busy;
    logic                     overrun;
    logic                     timeout_err;

    modport slave (
        input  frame_tick, enable_mask, sprite_x, sprite_y, sprite_colour, sprite_done,
        output start, erase, vga_x, vga_y, vga_colour, vga_plot, busy, overrun, timeout_err
    );

    modport master (
        output frame_tick, enable_mask, sprite_x, sprite_y, sprite_colour, sprite_done,
        input  start, erase, vga_x, vga_y, vga_colour, vga_plot, busy, overrun, timeout_err
    );
endinterface

// File: rtl/sprite_pixel_scheduler.sv
// Per-frame pixel scheduler sitting between the sprite drawers and the VGA adapter.
// Every frame tick walks the enabled drawer slots in index order.
// Each slot gets an erase pass (colour 000) and then a draw pass (sprite colour).
// Drawer pixels are forwarded to the VGA port with one cycle of latency.
// Off-screen coordinates are clipped.
// A drawer that never raises done is cut off after TIMEOUT cycles per pass.
module sprite_pixel_scheduler #(
    parameter int N_SPRITES = 7,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int TIMEOUT   = 64
) (
    input  logic clock,
    input  logic reset,
    sprite_pixel_scheduler_if.slave bus
);

    localparam int SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SPRITES - 1);
    localparam logic [6:0] TIMER_MAX = 7'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ST_E,
        ERASE,
        ST_D,
        DRAW,
        NEXT
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     sel;
    logic [6:0]           timer;

    logic [7:0]           cur_x;
    logic [6:0]           cur_y;
    logic [2:0]           cur_colour;
    logic                 cur_done;
    logic                 on_screen;
    logic [N_SPRITES-1:0] sel_onehot;
    logic                 pass_active;
    logic                 pass_exit;

    // Pick the selected drawer's stream out of the packed buses and pre-compute clipping and pass exit
    always_comb begin
        cur_x       = bus.sprite_x[int'(sel)*8 +: 8];
        cur_y       = bus.sprite_y[int'(sel)*7 +: 7];
        cur_colour  = bus.sprite_colour[int'(sel)*3 +: 3];
        cur_done    = bus.sprite_done[sel];
        on_screen   = ({1'b0, cur_x} < 9'(SCREEN_W)) && ({1'b0, cur_y} < 8'(SCREEN_H));
        sel_onehot  = {{(N_SPRITES-1){1'b0}}, 1'b1} << sel;
        pass_active = (state == ERASE) || (state == DRAW);
        pass_exit   = cur_done || (timer == TIMER_MAX);
    end

    // Frame sequencer with every output registered alongside the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            sel             <= '0;
            timer           <= '0;
            bus.start       <= '0;
            bus.erase       <= 1'b0;
            bus.vga_x       <= '0;
            bus.vga_y       <= '0;
            bus.vga_colour  <= '0;
            bus.vga_plot    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.start    <= '0;
            bus.vga_plot <= 1'b0;
            bus.overrun  <= bus.frame_tick && (state != IDLE);

            if (pass_active && !cur_done) begin
                bus.vga_x      <= cur_x;
                bus.vga_y      <= cur_y;
                bus.vga_colour <= (state == DRAW) ? cur_colour : 3'b000;
                bus.vga_plot   <= on_screen;
            end

            case (state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        sel      <= '0;
                        state    <= SCAN;
                        bus.busy <= 1'b1;
                    end
                end

                SCAN: begin
                    if (bus.enable_mask[sel]) begin
                        state     <= ST_E;
                        bus.start <= sel_onehot;
                        bus.erase <= 1'b1;
                        timer     <= '0;
                    end else if (sel == LAST_SEL) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        sel <= sel + SEL_W'(1);
                    end
                end

                ST_E: begin
                    timer <= '0;
                    state <= ERASE;
                end

                ERASE: begin
                    if (pass_exit) begin
                        if (!cur_done) begin
                            bus.timeout_err <= 1'b1;
                        end
                        state     <= ST_D;
                        bus.start <= sel_onehot;
                        bus.erase <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 7'd1;
                    end
                end

                ST_D: begin
                    timer <= '0;
                    state <= DRAW;
                end

                DRAW: begin
                    if (pass_exit) begin
                        if (!cur_done) begin
                            bus.timeout_err <= 1'b1;
                        end
                        state <= NEXT;
                    end else begin
                        timer <= timer + 7'd1;
                    end
                end

                NEXT: begin
                    if (sel == LAST_SEL) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        sel   <= sel + SEL_W'(1);
                        state <= SCAN;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.erase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Randomised scoreboard bench for sprite_pixel_scheduler.
// Each drawer is modelled as a table of coordinates replayed from its start pulse.
// A frame's expected pixels and its length come from the slot visiting rules.
// A monitor compares every plotted pixel against the expected queue.
module tb_sprite_pixel_scheduler;

    localparam int N    = 7;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int TO   = 64;
    localparam int HUNG = 1000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic reset;

    int   errors = 0;
    int   checks = 0;
    pix_t exp_q[$];
    pix_t got_pix;
    pix_t exp_pix;

    logic [7:0] xt[N][64];
    logic [6:0] yt[N][64];
    logic [2:0] col[N];
    int         plen[N];
    int         cnt[N];
    int         start_seen;
    int         ovr_seen;
    bit         exp_to;

    sprite_pixel_scheduler_if #(.N_SPRITES(N)) bus ();

    sprite_pixel_scheduler #(
        .N_SPRITES(N),
        .SCREEN_W(W),
        .SCREEN_H(H),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Drawer model: counter restarts on its start pulse, done once the table is exhausted
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (reset) cnt[i] <= HUNG;
            else if (bus.start[i]) cnt[i] <= 0;
            else if (cnt[i] < HUNG) cnt[i] <= cnt[i] + 1;
        end
    end

    // Drawer outputs presented on the packed buses
    always_comb begin
        bus.sprite_x      = '0;
        bus.sprite_y      = '0;
        bus.sprite_colour = '0;
        bus.sprite_done   = '0;
        for (int i = 0; i < N; i++) begin
            bus.sprite_x[i*8 +: 8]      = xt[i][cnt[i] % 64];
            bus.sprite_y[i*7 +: 7]      = yt[i][cnt[i] % 64];
            bus.sprite_colour[i*3 +: 3] = col[i];
            bus.sprite_done[i]          = (cnt[i] >= plen[i]);
        end
    end

    // Monitor: every plotted pixel must be the next expected one
    always @(negedge clock) begin
        if (bus.vga_plot === 1'b1) begin
            checks++;
            got_pix = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pixel_extra: got x=%0d y=%0d c=%0d, required no plot",
                         got_pix.x, got_pix.y, got_pix.c);
            end else begin
                exp_pix = exp_q.pop_front();
                if (got_pix !== exp_pix) begin
                    errors++;
                    $display("[TB] FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             got_pix.x, got_pix.y, got_pix.c, exp_pix.x, exp_pix.y, exp_pix.c);
                end
            end
        end
        if (bus.start !== '0) start_seen += $countones(bus.start);
        if (bus.overrun === 1'b1) ovr_seen++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Reference frame: expected pixels are queued, the frame length in cycles is returned
    task automatic modelFrame(input logic [N-1:0] mask, output int dur);
        int n;
        dur = 0;
        for (int s = 0; s < N; s++) begin
            if (mask[s]) begin
                n = (plen[s] < TO) ? plen[s] : TO;
                dur += 4 + 2 * ((plen[s] < TO) ? plen[s] + 1 : TO);
                if (plen[s] >= TO) exp_to = 1'b1;
                for (int pass = 0; pass < 2; pass++) begin
                    for (int k = 0; k < n; k++) begin
                        if (int'(xt[s][k]) < W && int'(yt[s][k]) < H)
                            exp_q.push_back('{x: xt[s][k], y: yt[s][k],
                                              c: (pass == 0) ? 3'b000 : col[s]});
                    end
                end
            end else begin
                dur += 1;
            end
        end
    endtask

    task automatic setDrawer(input int s, input int len);
        plen[s] = len;
        col[s]  = 3'($urandom_range(0, 7));
        for (int k = 0; k < 64; k++) begin
            xt[s][k] = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 170));
            yt[s][k] = ($urandom % 4 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 125));
        end
    endtask

    // One frame: tick_at <0 random extra tick, 0 none, >0 extra tick on that busy cycle
    task automatic applyStimulus(input logic [N-1:0] mask, input int tick_at);
        int dur, cycles, extra, want_ovr;
        want_ovr = 0;
        modelFrame(mask, dur);
        if (tick_at >= 0) extra = tick_at;
        else extra = ($urandom % 2 == 1) ? int'($urandom_range(1, dur)) : 0;
        @(negedge clock);
        bus.enable_mask = mask;
        start_seen = 0;
        ovr_seen = 0;
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 5000) begin
            cycles++;
            bus.frame_tick = (cycles == extra);
            if (cycles == extra) want_ovr = 1;
            @(negedge clock);
        end
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("frame_cycles", cycles, dur);
        checkOutput("pixels_missing", exp_q.size(), 0);
        exp_q.delete();
        checkOutput("start_pulses", start_seen, 2 * $countones(mask));
        checkOutput("overrun_pulses", ovr_seen, want_ovr);
        checkOutput("timeout_err", int'(bus.timeout_err), int'(exp_to));
        checkOutput("busy_after_frame", int'(bus.busy), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_start"}, int'(bus.start), 0);
        checkOutput({tag, "_erase"}, int'(bus.erase), 0);
        checkOutput({tag, "_vga_xyc"}, int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        checkOutput({tag, "_vga_plot"}, int'(bus.vga_plot), 0);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_flags"}, int'({bus.overrun, bus.timeout_err}), 0);
    endtask

    // Global time bound so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of run, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        logic [N-1:0] rmask;
        exp_to = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enable_mask = '0;
        for (int s = 0; s < N; s++) setDrawer(s, 5);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkResetState("reset");
        reset = 1'b0;

        // Single sprite, 13 pixels at (5,7) white
        for (int k = 0; k < 64; k++) begin xt[0][k] = 8'd5; yt[0][k] = 7'd7; end
        plen[0] = 13;
        col[0] = 3'b111;
        $display("[TB] single sprite frame");
        applyStimulus(7'b0000001, 0);

        // Empty frame: only scan cycles
        $display("[TB] empty frame");
        applyStimulus(7'b0000000, 0);

        // Clipping at the right edge, the bottom edge and the terminal coordinate
        for (int k = 0; k < 64; k++) begin
            xt[0][k] = 8'(158 + (k % 6)); yt[0][k] = 7'd7;
            xt[4][k] = 8'd10;             yt[4][k] = 7'(117 + (k % 6));
            xt[6][k] = 8'd255;            yt[6][k] = 7'd127;
        end
        plen[0] = 6; plen[4] = 6; plen[6] = 3;
        $display("[TB] clipping frame");
        applyStimulus(7'b1010001, 0);

        // Extra tick three cycles into the draw pass
        for (int k = 0; k < 64; k++) begin xt[0][k] = 8'(20 + k); yt[0][k] = 7'd30; end
        plen[0] = 13;
        $display("[TB] overrun frame");
        applyStimulus(7'b0000001, 20);
        applyStimulus(7'b0000001, 0);

        // Hung drawer on slot 2, slot 3 still serviced, flag sticky
        setDrawer(2, HUNG);
        setDrawer(3, 10);
        $display("[TB] timeout frame");
        applyStimulus(7'b0001100, 0);
        setDrawer(3, 7);
        applyStimulus(7'b0001000, 0);

        // Randomised frames
        for (int f = 0; f < 12; f++) begin
            for (int s = 0; s < N; s++)
                setDrawer(s, ($urandom % 8 == 0) ? HUNG : int'($urandom_range(0, 40)));
            rmask = 7'($urandom);
            $display("[TB] random frame %0d mask=%b", f, rmask);
            applyStimulus(rmask, -1);
        end

        // Reset during the erase pass of slot 1
        setDrawer(1, 20);
        for (int k = 0; k < 64; k++) begin xt[1][k] = 8'(40 + k); yt[1][k] = 7'd50; end
        modelFrame(7'b0000010, w);
        @(negedge clock);
        bus.enable_mask = 7'b0000010;
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        w = 0;
        while (bus.erase !== 1'b1 && w < 50) begin
            w++;
            @(negedge clock);
        end
        checkOutput("erase_reached", int'(bus.erase), 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkResetState("mid_reset");
        exp_q.delete();
        exp_to = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("idle_after_reset", int'(bus.busy), 0);
        setDrawer(0, 9);
        setDrawer(1, 11);
        $display("[TB] frame after reset");
        applyStimulus(7'b0000011, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
